// File: rtl/echo_pkg.sv
// Shared widths, types and frame-counter helpers for the echo canceller front end.
// Also imported by the sig16b_to_double front end.
package echo_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 13;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef logic [CW-1:0] cnt_t;
  typedef logic [DW-1:0] sample_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t CntZero     = '0;
  localparam cnt_t CntOne      = cnt_t'(1);
  localparam cnt_t CntMinFrame = cnt_t'(2);
  localparam ptr_t FillMax     = ptr_t'(DEPTH - 1);

  // Frames shorter than two cycles tick on every enabled cycle.
  function automatic logic is_last_cycle(input cnt_t cnt, input cnt_t len);
    return (len < CntMinFrame) || (cnt == len - CntOne);
  endfunction

endpackage

// File: rtl/echo_lag_ram.sv
// Far-end bulk-delay line storage: one sample per frame.
// Synchronous write, asynchronous read.
module echo_lag_ram
  import echo_pkg::*;
(
  input  logic          clk_operation,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk_operation) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/echo_frame_sampler.sv
// Frame counter, sample capture and per-frame aligned near/far-end output pair
// for the lag-16 echo canceller.
module echo_frame_sampler
  import echo_pkg::*;
(
  input  logic          clk_operation,
  input  logic          rst,
  input  logic          enable,
  input  logic [CW-1:0] sampling_cycle,
  input  logic [7:0]    set_bulk_delay,
  input  logic          clr_flags,
  input  logic [DW-1:0] mic_sample,
  input  logic          mic_valid,
  input  logic [DW-1:0] ref_sample,
  input  logic          ref_valid,
  output logic [CW-1:0] sampling_cycle_counter,
  output logic [DW-1:0] sig16b,
  output logic [DW-1:0] sig16b_lag,
  output logic          frame_strobe,
  output logic          lag_valid,
  output logic          overrun,
  output logic          underrun
);

  cnt_t       counter_q, counter_d;
  sample_t    mic_hold_q, mic_hold_d, ref_hold_q, ref_hold_d;
  sample_t    sig_q, sig_d, lag_q, lag_d;
  ptr_t       wr_ptr_q, wr_ptr_d, fill_q, fill_d, rd_addr;
  logic [7:0] delay_q, delay_d;
  logic [1:0] mic_cnt_q, mic_cnt_d;
  logic       strobe_q, lag_valid_q, lag_valid_d;
  logic       overrun_q, overrun_d, underrun_q, underrun_d;
  logic       tick, delay_changed;
  logic [AW:0] fill_inc;
  sample_t    ram_rdata;

  assign tick          = enable & is_last_cycle(counter_q, sampling_cycle);
  assign delay_changed = set_bulk_delay != delay_q;
  assign rd_addr       = wr_ptr_q - ptr_t'(set_bulk_delay);
  assign fill_inc      = {1'b0, fill_q} + (AW+1)'(1);

  always_comb begin
    counter_d   = counter_q;
    mic_hold_d  = mic_valid ? mic_sample : mic_hold_q;
    ref_hold_d  = ref_valid ? ref_sample : ref_hold_q;
    mic_cnt_d   = mic_cnt_q;
    overrun_d   = overrun_q & ~clr_flags;
    underrun_d  = underrun_q & ~clr_flags;
    sig_d       = sig_q;
    lag_d       = lag_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    lag_valid_d = lag_valid_q;
    delay_d     = delay_q;

    if (enable) counter_d = tick ? CntZero : counter_q + CntOne;

    // A strobe on the tick cycle is the first of the next frame.
    if (tick) begin
      mic_cnt_d = {1'b0, mic_valid};
    end else if (mic_valid && (mic_cnt_q != 2'd2)) begin
      mic_cnt_d = mic_cnt_q + 2'd1;
    end

    if (tick) begin
      if (mic_cnt_q == 2'd2) overrun_d = 1'b1;
      if (mic_cnt_q == 2'd0) underrun_d = 1'b1;
      sig_d    = mic_hold_q;
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
      delay_d  = set_bulk_delay;
      if (delay_changed) begin
        lag_d       = '0;
        fill_d      = '0;
        lag_valid_d = 1'b0;
      end else begin
        if (fill_q >= ptr_t'(set_bulk_delay)) begin
          lag_d = (set_bulk_delay == 8'd0) ? ref_hold_q : ram_rdata;
        end else begin
          lag_d = '0;
        end
        if (fill_q != FillMax) fill_d = fill_q + ptr_t'(1);
        lag_valid_d = fill_inc >= (AW+1)'(set_bulk_delay);
      end
    end
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      counter_q   <= CntZero;
      mic_hold_q  <= '0;
      ref_hold_q  <= '0;
      mic_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      sig_q       <= '0;
      lag_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      lag_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
      // Track the current setting so a steady delay is not seen as a change.
      delay_q     <= set_bulk_delay;
    end else begin
      counter_q   <= counter_d;
      mic_hold_q  <= mic_hold_d;
      ref_hold_q  <= ref_hold_d;
      mic_cnt_q   <= mic_cnt_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      sig_q       <= sig_d;
      lag_q       <= lag_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      lag_valid_q <= lag_valid_d;
      strobe_q    <= tick;
      delay_q     <= delay_d;
    end
  end

  echo_lag_ram u_lag_ram (
    .clk_operation (clk_operation),
    .we            (tick),
    .waddr         (wr_ptr_q),
    .wdata         (ref_hold_q),
    .raddr         (rd_addr),
    .rdata         (ram_rdata)
  );

  assign sampling_cycle_counter = counter_q;
  assign sig16b                 = sig_q;
  assign sig16b_lag             = lag_q;
  assign frame_strobe           = strobe_q;
  assign lag_valid              = lag_valid_q;
  assign overrun                = overrun_q;
  assign underrun               = underrun_q;

endmodule

// File: tb/tb_echo_frame_sampler.sv
// Directed bench for echo_frame_sampler: frame-level reference model checked every
// cycle, plus hand-computed expectations at key points.
module tb_echo_frame_sampler;

  logic        clk_operation = 1'b0;
  logic        rst, enable, clr_flags, mic_valid, ref_valid;
  logic [12:0] sampling_cycle;
  logic [7:0]  set_bulk_delay;
  logic [15:0] mic_sample, ref_sample;
  logic [12:0] sampling_cycle_counter;
  logic [15:0] sig16b, sig16b_lag;
  logic        frame_strobe, lag_valid, overrun, underrun;

  int n_cmp  = 0;
  int n_fail = 0;

  echo_frame_sampler dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .enable                 (enable),
    .sampling_cycle         (sampling_cycle),
    .set_bulk_delay         (set_bulk_delay),
    .clr_flags              (clr_flags),
    .mic_sample             (mic_sample),
    .mic_valid              (mic_valid),
    .ref_sample             (ref_sample),
    .ref_valid              (ref_valid),
    .sampling_cycle_counter (sampling_cycle_counter),
    .sig16b                 (sig16b),
    .sig16b_lag             (sig16b_lag),
    .frame_strobe           (frame_strobe),
    .lag_valid              (lag_valid),
    .overrun                (overrun),
    .underrun               (underrun)
  );

  always #5 clk_operation = ~clk_operation;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: one record per tick, outputs derived from frame history.
  logic [12:0] m_cnt;
  logic [15:0] m_sig, m_lag, m_mic, m_ref;
  logic        m_fs, m_lv, m_ov, m_un;
  int          m_fill, m_micn, m_dprev;
  logic [15:0] frames[$];
  bit          armed = 1'b0;

  always @(posedge clk_operation) begin
    bit tick;
    int d;
    if (rst) begin
      m_cnt = '0; m_sig = '0; m_lag = '0; m_mic = '0; m_ref = '0;
      m_fs = 0; m_lv = 0; m_ov = 0; m_un = 0;
      m_fill = 0; m_micn = 0; m_dprev = int'(set_bulk_delay);
      frames.delete();
      armed = 1'b1;
    end else if (armed) begin
      tick = enable && ((sampling_cycle < 13'd2) || (m_cnt == sampling_cycle - 13'd1));
      m_fs = tick;
      if (clr_flags) begin m_ov = 0; m_un = 0; end
      if (tick) begin
        d = int'(set_bulk_delay);
        if (m_micn >= 2) m_ov = 1;
        if (m_micn == 0) m_un = 1;
        m_sig = m_mic;
        if (d != m_dprev) begin
          m_lag = '0; m_lv = 0; m_fill = 0;
        end else begin
          if (m_fill >= d) m_lag = (d == 0) ? m_ref : frames[frames.size() - d];
          else m_lag = '0;
          m_lv = (m_fill + 1 >= d);
          m_fill = (m_fill + 1 > 255) ? 255 : m_fill + 1;
        end
        frames.push_back(m_ref);
        if (frames.size() > 256) void'(frames.pop_front());
        m_dprev = d;
        m_micn = mic_valid ? 1 : 0;
      end else if (mic_valid && m_micn < 2) begin
        m_micn++;
      end
      if (enable) m_cnt = tick ? 13'd0 : m_cnt + 13'd1;
      if (mic_valid) m_mic = mic_sample;
      if (ref_valid) m_ref = ref_sample;
    end
  end

  always @(negedge clk_operation) begin
    if (armed) begin
      chk("counter", 32'(sampling_cycle_counter), 32'(m_cnt));
      chk("sig16b", 32'(sig16b), 32'(m_sig));
      chk("sig16b_lag", 32'(sig16b_lag), 32'(m_lag));
      chk("frame_strobe", 32'(frame_strobe), 32'(m_fs));
      chk("lag_valid", 32'(lag_valid), 32'(m_lv));
      chk("overrun", 32'(overrun), 32'(m_ov));
      chk("underrun", 32'(underrun), 32'(m_un));
    end
  end

  task automatic cyc();
    @(posedge clk_operation);
    #1;
  endtask

  // One frame from counter==0: mic at 2 (and 4), ref at 3, optional clr and tick-cycle mic.
  task automatic run_frame(input int mic_n, input logic [15:0] m1, input logic [15:0] m2,
                           input bit rv, input logic [15:0] rval, input int clr_pos,
                           input bit mt, input logic [15:0] mtval);
    int len;
    len = (sampling_cycle < 13'd2) ? 1 : int'(sampling_cycle);
    for (int i = 0; i < len; i++) begin
      mic_valid = 1'b0; ref_valid = 1'b0; clr_flags = (i == clr_pos);
      if (mic_n >= 1 && i == 2) begin mic_valid = 1'b1; mic_sample = m1; end
      if (mic_n >= 2 && i == 4) begin mic_valid = 1'b1; mic_sample = m2; end
      if (rv && i == 3) begin ref_valid = 1'b1; ref_sample = rval; end
      if (mt && i == len - 1) begin mic_valid = 1'b1; mic_sample = mtval; end
      cyc();
    end
    mic_valid = 1'b0; ref_valid = 1'b0; clr_flags = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clr_flags = 1'b0; mic_valid = 1'b0; ref_valid = 1'b0;
    sampling_cycle = 13'd8; set_bulk_delay = 8'd3; mic_sample = '0; ref_sample = '0;
    repeat (3) cyc();
    chk("rst_counter", 32'(sampling_cycle_counter), 0);
    chk("rst_sig16b", 32'(sig16b), 0);
    chk("rst_lag_valid", 32'(lag_valid), 0);

    // Counter runs and wraps; D=3 fill-up with ref 1,2,3,...
    rst = 1'b0; enable = 1'b1;
    cyc(); cyc(); cyc();
    chk("cnt_run3", 32'(sampling_cycle_counter), 3);
    chk("no_strobe_mid", 32'(frame_strobe), 0);
    for (int i = 3; i < 8; i++) begin
      if (i == 3) begin ref_valid = 1'b1; ref_sample = 16'h0001; end
      cyc();
      ref_valid = 1'b0;
    end
    chk("wrap_cnt", 32'(sampling_cycle_counter), 0);
    chk("wrap_strobe", 32'(frame_strobe), 1);
    chk("f0_lag", 32'(sig16b_lag), 0);
    chk("f0_underrun", 32'(underrun), 1);
    run_frame(0, 0, 0, 1, 16'h0002, -1, 0, 0);
    chk("f1_lag_valid", 32'(lag_valid), 0);
    run_frame(0, 0, 0, 1, 16'h0003, -1, 0, 0);
    chk("f2_lag", 32'(sig16b_lag), 0);
    run_frame(0, 0, 0, 1, 16'h0004, -1, 0, 0);
    chk("f3_lag", 32'(sig16b_lag), 32'h0001);
    chk("f3_lag_valid", 32'(lag_valid), 1);
    run_frame(0, 0, 0, 1, 16'h0005, -1, 0, 0);
    chk("f4_lag", 32'(sig16b_lag), 32'h0002);

    // D=0 pass-through, tick-cycle mic strobe goes to the next frame
    set_bulk_delay = 8'd0;
    run_frame(1, 16'h1234, 0, 1, 16'hABCD, -1, 0, 0);
    chk("d0_sig", 32'(sig16b), 32'h1234);
    chk("d0_change_lag", 32'(sig16b_lag), 0);
    run_frame(0, 0, 0, 0, 0, -1, 0, 0);
    chk("d0_lag", 32'(sig16b_lag), 32'hABCD);
    run_frame(0, 0, 0, 0, 0, -1, 1, 16'h5555);
    chk("tickmic_not_yet", 32'(sig16b), 32'h1234);
    run_frame(0, 0, 0, 0, 0, -1, 0, 0);
    chk("tickmic_next", 32'(sig16b), 32'h5555);

    // Flags
    run_frame(2, 16'h1111, 16'h2222, 0, 0, 1, 0, 0);
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_last_wins", 32'(sig16b), 32'h2222);
    chk("ovr_un_clr", 32'(underrun), 0);
    run_frame(0, 0, 0, 0, 0, 1, 0, 0);
    chk("und_set", 32'(underrun), 1);
    chk("und_repeat", 32'(sig16b), 32'h2222);
    run_frame(1, 16'h3333, 0, 0, 0, 1, 0, 0);
    chk("clr_ovr", 32'(overrun), 0);
    chk("clr_und", 32'(underrun), 0);
    run_frame(0, 0, 0, 0, 0, 7, 0, 0);
    chk("set_beats_clr", 32'(underrun), 1);

    // Delay change 3 -> 5
    set_bulk_delay = 8'd3;
    for (int j = 0; j < 6; j++) run_frame(1, 16'h0100 + 16'(j), 0, 1, 16'h0010 + 16'(j), -1, 0, 0);
    chk("d3_valid", 32'(lag_valid), 1);
    set_bulk_delay = 8'd5;
    for (int j = 0; j < 7; j++) begin
      run_frame(1, 16'h0200 + 16'(j), 0, 1, 16'h0020 + 16'(j), -1, 0, 0);
      if (j == 0) chk("d5_drop_valid", 32'(lag_valid), 0);
      if (j == 0) chk("d5_drop_lag", 32'(sig16b_lag), 0);
      if (j == 5) chk("d5_still_zero", 32'(sig16b_lag), 0);
      if (j == 6) chk("d5_refilled", 32'(sig16b_lag), 32'h0021);
    end

    // sampling_cycle=1: tick every cycle
    sampling_cycle = 13'd1;
    mic_valid = 1'b1; mic_sample = 16'h0A01;
    cyc();
    mic_valid = 1'b0;
    cyc();
    chk("sc1_sig", 32'(sig16b), 32'h0A01);
    chk("sc1_cnt", 32'(sampling_cycle_counter), 0);
    chk("sc1_strobe", 32'(frame_strobe), 1);
    repeat (3) cyc();
    sampling_cycle = 13'd8;

    // enable=0 freezes the counter
    cyc(); cyc();
    enable = 1'b0;
    mic_valid = 1'b1; mic_sample = 16'h0B0B;
    cyc();
    mic_valid = 1'b0;
    cyc(); cyc();
    chk("frozen_cnt", 32'(sampling_cycle_counter), 2);
    chk("frozen_strobe", 32'(frame_strobe), 0);
    enable = 1'b1;
    repeat (6) cyc();
    chk("unfrozen_sig", 32'(sig16b), 32'h0B0B);

    // Reset mid-frame at counter=4, then refill with D=5
    repeat (4) cyc();
    chk("pre_rst_cnt", 32'(sampling_cycle_counter), 4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_cnt", 32'(sampling_cycle_counter), 0);
    chk("mrst_sig", 32'(sig16b), 0);
    chk("mrst_lag", 32'(sig16b_lag), 0);
    chk("mrst_strobe", 32'(frame_strobe), 0);
    chk("mrst_valid", 32'(lag_valid), 0);
    for (int j = 0; j < 7; j++) begin
      run_frame(1, 16'h0300 + 16'(j), 0, 1, 16'h0030 + 16'(j), -1, 0, 0);
      if (j == 3) chk("rf_valid_low", 32'(lag_valid), 0);
      if (j == 5) chk("rf_lag", 32'(sig16b_lag), 32'h0030);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
